// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: examines DIGIT bits per cycle MSB-first and stops at the first differing digit.
// Optional signed mode is compiled in with `define SEQ_MAG_COMPARATOR_SIGNED_EN (adds the is_signed port).
module seq_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data_a,
    input  logic [WIDTH-1:0]             data_b,
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    input  logic                         is_signed,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         greater,
    output logic                         lesser,
    output logic                         equal,
    output logic [$clog2(WIDTH/DIGIT):0] cycles
);

    localparam int ND = WIDTH / DIGIT;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int CW = $clog2(ND) + 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, flip;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] dig_a, dig_b;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    assign flip = is_signed ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
`else
    assign flip = '0;
`endif

    assign dig_a     = DIGIT'(a_r >> (int'(idx) * DIGIT));
    assign dig_b     = DIGIT'(b_r >> (int'(idx) * DIGIT));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            cycles  <= '0;
            greater <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= data_a ^ flip;
                        b_r    <= data_b ^ flip;
                        idx    <= IW'(ND - 1);
                        cycles <= '0;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    cycles <= cycles + CW'(1);
                    if (dig_a != dig_b) begin
                        greater <= (dig_a > dig_b);
                        lesser  <= (dig_a < dig_b);
                        state   <= DONE;
                    end else if (idx == '0) begin
                        equal <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    // cycles is left alone so the count stays readable until the next transfer.
                    if (out_ready) begin
                        greater <= 1'b0;
                        lesser  <= 1'b0;
                        equal   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 SHALL provide parameter DIGIT, default 1, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port in_valid  input  1  operand pair offered.
REQ-006 SHALL provide port in_ready  output  1  block accepts operands.
REQ-007 SHALL provide port data_a  input  WIDTH  operand A.
REQ-008 SHALL provide port data_b  input  WIDTH  operand B.
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer takes result.
REQ-011 SHALL provide ports greater, lesser, equal  output  1 each  A>B, A<B, A==B.
REQ-012 SHALL provide port cycles  output  clog2(WIDTH/DIGIT)+1  digits examined for current result.

Function
REQ-013 SHALL implement FSM states IDLE, COMPARE, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; transfer occurs when in_valid&&in_ready at a rising edge.
REQ-015 On transfer, SHALL capture data_a/data_b into internal registers and go IDLE->COMPARE; input changes afterwards SHALL have no effect.
REQ-016 In COMPARE, SHALL examine one DIGIT-bit digit per cycle, MSB-first, digit index from WIDTH/DIGIT-1 down to 0, incrementing cycles each cycle.
REQ-017 If the current digits differ, SHALL set greater or lesser by unsigned digit compare and go to DONE in that cycle (early termination).
REQ-018 If the least-significant digits are equal, SHALL set equal and go to DONE.
REQ-019 Latency from transfer edge to out_valid SHALL be k+1 cycles, k = digits examined (1..WIDTH/DIGIT).
REQ-020 out_valid SHALL be 1 only in DONE; exactly one of greater/lesser/equal SHALL be 1 while out_valid=1; all three SHALL be 0 otherwise.
REQ-021 Result and cycles SHALL hold stable in DONE while out_ready=0.
REQ-022 DONE with out_ready=1 SHALL return to IDLE next edge and clear greater/lesser/equal; cycles holds until next transfer, then resets to 0.
REQ-023 in_valid asserted outside IDLE SHALL be ignored (no capture, no state change).
REQ-024 Back-to-back throughput: one comparison per k+2 cycles minimum.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, greater=lesser=equal=0, cycles=0, operand registers 0, regardless of state, including mid-COMPARE.
REQ-026 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SEQ_MAG_COMPARATOR_SIGNED_EN SHALL gate signed comparison.
REQ-028 With macro defined: extra port is_signed input 1, sampled at transfer; when 1, the MSB of both captured operands SHALL be inverted before comparison (two's-complement order); when 0, unsigned.
REQ-029 Without macro: port is_signed SHALL not exist; comparison always unsigned.

Verification
REQ-030 WIDTH=8, DIGIT=1: A=0x80, B=0x7F -> greater=1, cycles=1, out_valid 2 cycles after transfer.
REQ-031 WIDTH=8, DIGIT=1: A=0x5A, B=0x5A -> equal=1, cycles=8, out_valid 9 cycles after transfer.
REQ-032 WIDTH=8, DIGIT=4: A=0x35, B=0x37 -> lesser=1, cycles=2; out_ready held 0 for 5 cycles -> result stable, in_ready=0, in_valid pulses ignored.
REQ-033 rst_n pulsed low during COMPARE (WIDTH=8, DIGIT=1, A=B=0xFF, third cycle) -> all outputs 0 immediately, IDLE after release; new pair 0x01 vs 0x02 -> lesser=1, cycles=7.
REQ-034 Macro defined, is_signed=1: A=0x80 (-128), B=0x7F (127) -> lesser=1; same with is_signed=0 -> greater=1.
REQ-035 Random 1000 pairs per (WIDTH,DIGIT) in {(8,1),(8,2),(16,4)} with random out_ready stalls -> results match reference model, one-hot, no lost/duplicated results.
